// File: rtl/vec_pkg.sv
// Shared definitions for the vector loader: default geometry, field widths
// and the loader state type.
package vec_pkg;

   localparam int BITS_DEF = 8;
   localparam int N_DEF    = 4;
   localparam int LEN_W    = 8;
   localparam int SEL_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2
   } ld_state_t;

   // A command length is usable only when it names between 1 and n elements.
   function automatic logic len_ok(input logic [LEN_W-1:0] len, input int n);
      return (len != '0) && (len <= LEN_W'(n));
   endfunction

endpackage

// File: rtl/vec_loader_if.sv
// Command/element stream in, assembled vector and register-bank write out.
interface vec_loader_if
   import vec_pkg::*;
#(
   parameter int BITS = BITS_DEF,
   parameter int N    = N_DEF
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [SEL_W-1:0] cmd_sel;
   logic [LEN_W-1:0] cmd_len;
   logic             elem_valid;
   logic             elem_ready;
   logic [BITS-1:0]  elem_data;
   logic             abort;
   logic [BITS-1:0]  vec_out [N-1:0];
   logic [LEN_W-1:0] vec_len;
   logic [SEL_W-1:0] vec_sel;
   logic             write;
   logic             busy;
   logic             len_err;

   modport slave (
      input  cmd_valid, cmd_sel, cmd_len, elem_valid, elem_data, abort,
      output cmd_ready, elem_ready, vec_out, vec_len, vec_sel, write, busy, len_err
   );

   modport master (
      output cmd_valid, cmd_sel, cmd_len, elem_valid, elem_data, abort,
      input  cmd_ready, elem_ready, vec_out, vec_len, vec_sel, write, busy, len_err
   );
endinterface

// File: rtl/vec_loader.sv
// Collects cmd_len stream elements into a zero-padded vector, then issues a
// single register-bank write strobe carrying the vector, length and index.
module vec_loader
   import vec_pkg::*;
#(
   parameter int BITS = BITS_DEF,
   parameter int N    = N_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   vec_loader_if.slave  bus
);
   localparam int CNT_W = $clog2(N + 1);

   ld_state_t        state_reg;
   logic [CNT_W-1:0] count_reg;
   logic [LEN_W-1:0] len_reg;
   logic [SEL_W-1:0] sel_reg;
   logic [BITS-1:0]  vec_reg [N-1:0];
   logic             write_reg;
   logic             err_reg;
   logic             cmd_ready_reg;
   logic             elem_en_reg;
   logic             busy_reg;

   logic             cmd_good;
   logic             cmd_take;
   logic             elem_take;
   logic             last_elem;

   assign cmd_good  = len_ok(bus.cmd_len, N);
   assign cmd_take  = cmd_ready_reg & bus.cmd_valid & cmd_good;
   assign elem_take = bus.elem_valid & bus.elem_ready;
   assign last_elem = (LEN_W'(count_reg) + LEN_W'(1)) == len_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         count_reg     <= '0;
         len_reg       <= '0;
         sel_reg       <= '0;
         write_reg     <= 1'b0;
         err_reg       <= 1'b0;
         cmd_ready_reg <= 1'b1;
         elem_en_reg   <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         write_reg <= 1'b0;
         err_reg   <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  if (cmd_good) begin
                     sel_reg       <= bus.cmd_sel;
                     len_reg       <= bus.cmd_len;
                     count_reg     <= '0;
                     state_reg     <= ST_LOAD;
                     cmd_ready_reg <= 1'b0;
                     elem_en_reg   <= 1'b1;
                     busy_reg      <= 1'b1;
                  end else begin
                     err_reg <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               // Abort wins over a simultaneous element; elem_ready is already low.
               if (bus.abort) begin
                  state_reg     <= ST_IDLE;
                  cmd_ready_reg <= 1'b1;
                  elem_en_reg   <= 1'b0;
                  busy_reg      <= 1'b0;
               end else if (bus.elem_valid) begin
                  count_reg <= count_reg + CNT_W'(1);
                  if (last_elem) begin
                     state_reg   <= ST_COMMIT;
                     write_reg   <= 1'b1;
                     elem_en_reg <= 1'b0;
                  end
               end
            end
            ST_COMMIT: begin
               state_reg     <= ST_IDLE;
               cmd_ready_reg <= 1'b1;
               busy_reg      <= 1'b0;
            end
            default: begin
               state_reg     <= ST_IDLE;
               cmd_ready_reg <= 1'b1;
               elem_en_reg   <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   // Clearing on command acceptance leaves elements [len..N-1] at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) vec_reg[i] <= '0;
      end else if (cmd_take) begin
         for (int i = 0; i < N; i++) vec_reg[i] <= '0;
      end else if (elem_take) begin
         for (int i = 0; i < N; i++) begin
            if (count_reg == CNT_W'(i)) vec_reg[i] <= bus.elem_data;
         end
      end
   end

   assign bus.cmd_ready  = cmd_ready_reg;
   assign bus.elem_ready = elem_en_reg & ~bus.abort;
   assign bus.busy       = busy_reg;
   assign bus.write      = write_reg;
   assign bus.len_err    = err_reg;
   assign bus.vec_len    = len_reg;
   assign bus.vec_sel    = sel_reg;

   for (genvar gi = 0; gi < N; gi++) begin : g_out
      assign bus.vec_out[gi] = vec_reg[gi];
   end

endmodule

// File: tb/tb_vec_loader.sv
// Directed bench for vec_loader: a transaction-level model is compared every
// cycle, and literal expectations pin the model at key points.
module tb_vec_loader;
   localparam int BITS = 8;
   localparam int N    = 4;

   logic clk = 1'b0;
   logic rst_n;

   vec_loader_if #(.BITS(BITS), .N(N)) bus ();

   vec_loader #(.BITS(BITS), .N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int wr_count = 0;
   int err_count = 0;
   bit chk_en = 1'b0;

   // Model state: whether a load/commit is underway and what has been gathered.
   bit        m_loading = 1'b0;
   bit        m_commit  = 1'b0;
   int        m_want    = 0;
   int        m_got     = 0;
   logic [7:0] m_vec [N] = '{default: 8'h00};
   logic [7:0] m_len = 8'h00;
   logic [3:0] m_sel = 4'h0;
   bit        m_write = 1'b0;
   bit        m_err   = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check_vec(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
      check({nm, "_v0"}, bus.vec_out[0], e0);
      check({nm, "_v1"}, bus.vec_out[1], e1);
      check({nm, "_v2"}, bus.vec_out[2], e2);
      check({nm, "_v3"}, bus.vec_out[3], e3);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_loading <= 1'b0;
         m_commit  <= 1'b0;
         m_want    <= 0;
         m_got     <= 0;
         for (int i = 0; i < N; i++) m_vec[i] <= 8'h00;
         m_len   <= 8'h00;
         m_sel   <= 4'h0;
         m_write <= 1'b0;
         m_err   <= 1'b0;
      end else begin
         m_write <= 1'b0;
         m_err   <= 1'b0;
         if (m_commit) begin
            m_commit <= 1'b0;
         end else if (m_loading) begin
            if (bus.abort) begin
               m_loading <= 1'b0;
            end else if (bus.elem_valid) begin
               m_vec[m_got] <= bus.elem_data;
               m_got <= m_got + 1;
               if (m_got + 1 == m_want) begin
                  m_loading <= 1'b0;
                  m_commit  <= 1'b1;
                  m_write   <= 1'b1;
               end
            end
         end else if (bus.cmd_valid) begin
            if (bus.cmd_len >= 8'd1 && bus.cmd_len <= 8'(N)) begin
               m_loading <= 1'b1;
               m_want    <= int'(bus.cmd_len);
               m_got     <= 0;
               m_len     <= bus.cmd_len;
               m_sel     <= bus.cmd_sel;
               for (int i = 0; i < N; i++) m_vec[i] <= 8'h00;
            end else begin
               m_err <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (bus.write === 1'b1) wr_count++;
      if (bus.len_err === 1'b1) err_count++;
      if (chk_en) begin
         check("cmd_ready", bus.cmd_ready, !(m_loading || m_commit));
         check("elem_ready", bus.elem_ready, m_loading && !bus.abort);
         check("busy", bus.busy, m_loading || m_commit);
         check("write", bus.write, m_write);
         check("len_err", bus.len_err, m_err);
         check("vec_len", bus.vec_len, m_len);
         check("vec_sel", bus.vec_sel, m_sel);
         for (int i = 0; i < N; i++) check("vec_out", bus.vec_out[i], m_vec[i]);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0;  bus.cmd_sel = 4'h0;  bus.cmd_len = 8'h00;
      bus.elem_valid = 1'b0; bus.elem_data = 8'h00; bus.abort = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      rst_n = 1'b1;
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_elem_ready", bus.elem_ready, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_write", bus.write, 0);
      check("rst_len", bus.vec_len, 0);
      check_vec("rst", 8'h00, 8'h00, 8'h00, 8'h00);
      step();

      // Basic load of three elements back-to-back
      bus.cmd_valid = 1'b1; bus.cmd_sel = 4'd1; bus.cmd_len = 8'd3;
      step();
      bus.cmd_valid = 1'b0;
      bus.elem_valid = 1'b1; bus.elem_data = 8'hFF; step();
      bus.elem_data = 8'h7E; step();
      bus.elem_data = 8'h7D; step();
      bus.elem_data = 8'h55; bus.abort = 1'b1;  // ignored during commit
      check("s1_write", bus.write, 1);
      check("s1_elem_ready", bus.elem_ready, 0);
      check("s1_len", bus.vec_len, 3);
      check("s1_sel", bus.vec_sel, 1);
      check_vec("s1", 8'hFF, 8'h7E, 8'h7D, 8'h00);
      step();
      bus.elem_valid = 1'b0; bus.abort = 1'b0;
      check("s1_write_off", bus.write, 0);
      check("s1_cmd_ready", bus.cmd_ready, 1);
      check("s1_wr_count", wr_count, 1);
      check_vec("s1_hold", 8'hFF, 8'h7E, 8'h7D, 8'h00);
      step();

      // Rejected lengths 0 and 5
      bus.cmd_valid = 1'b1; bus.cmd_sel = 4'd5; bus.cmd_len = 8'd0;
      step();
      check("s2_err0", bus.len_err, 1);
      check("s2_busy0", bus.busy, 0);
      bus.cmd_sel = 4'd6; bus.cmd_len = 8'd5;
      step();
      bus.cmd_valid = 1'b0;
      check("s2_err5", bus.len_err, 1);
      check("s2_ready5", bus.cmd_ready, 1);
      step();
      check("s2_err_off", bus.len_err, 0);
      check("s2_err_count", err_count, 2);
      check("s2_sel_hold", bus.vec_sel, 1);
      check("s2_len_hold", bus.vec_len, 3);
      check("s2_wr_count", wr_count, 1);
      check_vec("s2", 8'hFF, 8'h7E, 8'h7D, 8'h00);

      // Two elements with valid gaps
      bus.cmd_valid = 1'b1; bus.cmd_sel = 4'd2; bus.cmd_len = 8'd2;
      step();
      bus.cmd_valid = 1'b0;
      bus.elem_valid = 1'b1; bus.elem_data = 8'h11; step();
      bus.elem_valid = 1'b0; step();
      step();
      check("s3_no_write", bus.write, 0);
      bus.elem_valid = 1'b1; bus.elem_data = 8'h22; step();
      bus.elem_valid = 1'b0;
      check("s3_write", bus.write, 1);
      check("s3_len", bus.vec_len, 2);
      check("s3_sel", bus.vec_sel, 2);
      check_vec("s3", 8'h11, 8'h22, 8'h00, 8'h00);
      step();
      check("s3_wr_count", wr_count, 2);

      // Abort with a simultaneous element
      bus.cmd_valid = 1'b1; bus.cmd_sel = 4'd3; bus.cmd_len = 8'd4;
      step();
      bus.cmd_valid = 1'b0;
      bus.elem_valid = 1'b1; bus.elem_data = 8'hA1; step();
      bus.elem_data = 8'hA2; step();
      bus.elem_data = 8'hA3; bus.abort = 1'b1;
      #1;
      check("s4_elem_ready", bus.elem_ready, 0);
      step();
      bus.elem_valid = 1'b0; bus.abort = 1'b0;
      check("s4_cmd_ready", bus.cmd_ready, 1);
      check("s4_busy", bus.busy, 0);
      step();
      step();
      check("s4_wr_count", wr_count, 2);
      check_vec("s4", 8'hA1, 8'hA2, 8'h00, 8'h00);

      // Asynchronous reset in the middle of a load
      bus.cmd_valid = 1'b1; bus.cmd_sel = 4'd4; bus.cmd_len = 8'd4;
      step();
      bus.cmd_valid = 1'b0;
      bus.elem_valid = 1'b1; bus.elem_data = 8'h01; step();
      bus.elem_data = 8'h02; step();
      bus.elem_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("s5_busy", bus.busy, 0);
      check("s5_write", bus.write, 0);
      check("s5_len", bus.vec_len, 0);
      check("s5_cmd_ready", bus.cmd_ready, 1);
      check_vec("s5_rst", 8'h00, 8'h00, 8'h00, 8'h00);
      step();
      rst_n = 1'b1;
      bus.cmd_valid = 1'b1; bus.cmd_sel = 4'd9; bus.cmd_len = 8'd4;
      step();
      bus.cmd_valid = 1'b0;
      bus.elem_valid = 1'b1; bus.elem_data = 8'h05; step();
      bus.elem_data = 8'h06; step();
      bus.elem_data = 8'h07; step();
      bus.elem_data = 8'h08; step();
      bus.elem_valid = 1'b0;
      check("s5_full_write", bus.write, 1);
      check("s5_full_len", bus.vec_len, 4);
      check("s5_full_sel", bus.vec_sel, 9);
      check_vec("s5_full", 8'h05, 8'h06, 8'h07, 8'h08);
      step();
      check("s5_wr_count", wr_count, 3);

      // cmd_valid held high across two commands; second is shorter
      bus.cmd_valid = 1'b1; bus.cmd_sel = 4'd7; bus.cmd_len = 8'd3;
      step();
      bus.cmd_sel = 4'd8; bus.cmd_len = 8'd1;
      bus.elem_valid = 1'b1; bus.elem_data = 8'h09; step();
      bus.elem_data = 8'h0A; step();
      bus.elem_data = 8'h0B; step();
      bus.elem_valid = 1'b0;
      check("s6_write1", bus.write, 1);
      check_vec("s6_first", 8'h09, 8'h0A, 8'h0B, 8'h00);
      step();
      check("s6_idle_ready", bus.cmd_ready, 1);
      step();
      bus.cmd_valid = 1'b0;
      check("s6_busy2", bus.busy, 1);
      check_vec("s6_zeroed", 8'h00, 8'h00, 8'h00, 8'h00);
      bus.elem_valid = 1'b1; bus.elem_data = 8'h0C; step();
      bus.elem_valid = 1'b0;
      check("s6_write2", bus.write, 1);
      check("s6_len2", bus.vec_len, 1);
      check("s6_sel2", bus.vec_sel, 8);
      check_vec("s6_second", 8'h0C, 8'h00, 8'h00, 8'h00);
      step();
      step();
      check("s6_wr_count", wr_count, 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
